// File: rtl/sbilinear_pipe.sv
// Sum of NTAP arithmetically shifted signed taps, with optional per-tap rounding and output saturation.
// Latency 3 cycles at 1 vector/cycle; a stall collapses bubbles and in_ready drops only when all 3 stages are full.
module sbilinear_pipe #(
    parameter int DATA_W = 16,
    parameter int SHW    = 6,
    parameter int NTAP   = 4,
    parameter int CNT_W  = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [NTAP*DATA_W-1:0] v_flat,
    input  logic [NTAP*SHW-1:0]    s_flat,
    input  logic                   round_en,
    input  logic                   sat_en,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DATA_W-1:0]      out,
    output logic                   sat_flag,
    output logic [CNT_W-1:0]       ovf_cnt,
    input  logic                   cnt_clr
);

    localparam int TERM_W = DATA_W + 1;
    localparam int ACC_W  = DATA_W + 1 + $clog2(NTAP);

    localparam logic signed [ACC_W-1:0] MAX_V = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] MIN_V = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
    localparam logic [DATA_W-1:0] OUT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0] OUT_MIN = {1'b1, {(DATA_W-1){1'b0}}};

    typedef struct packed {
        logic                        sat;
        logic [NTAP-1:0][TERM_W-1:0] term;
    } s1_t;

    typedef struct packed {
        logic             sat;
        logic [ACC_W-1:0] sum;
    } s2_t;

    // One extra bit of headroom so the rounding offset can never wrap the tap.
    function automatic logic [TERM_W-1:0] tap_term(
        input logic [DATA_W-1:0] v,
        input logic [SHW-1:0]    s,
        input logic              rnd
    );
        logic signed [TERM_W-1:0] ext;
        logic signed [TERM_W-1:0] half;
        int unsigned              sh;
        sh   = (32'(s) >= DATA_W) ? DATA_W - 1 : 32'(s);
        ext  = $signed({v[DATA_W-1], v});
        half = '0;
        if (rnd && sh != 0)
            half = TERM_W'(1) << (sh - 1);
        return (ext + half) >>> sh;
    endfunction

    logic v1, v2, v3;
    logic ld1, ld2, ld3;

    s1_t s1_d, s1_q;
    s2_t s2_d, s2_q;

    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] sum_s;
    logic [DATA_W-1:0]       out_d;
    logic                    flag_d;
    logic                    over;
    logic                    under;

    assign ld3       = !v3 || out_ready;
    assign ld2       = !v2 || ld3;
    assign ld1       = !v1 || ld2;
    assign in_ready  = ld1;
    assign out_valid = v3;

    always_comb begin
        s1_d     = '0;
        s1_d.sat = sat_en;
        for (int i = 0; i < NTAP; i++)
            s1_d.term[i] = tap_term(v_flat[i*DATA_W +: DATA_W], s_flat[i*SHW +: SHW], round_en);
    end

    always_comb begin
        acc = '0;
        for (int i = 0; i < NTAP; i++)
            acc = acc + ACC_W'($signed(s1_q.term[i]));
        s2_d     = '0;
        s2_d.sat = s1_q.sat;
        s2_d.sum = acc;
    end

    always_comb begin
        sum_s  = $signed(s2_q.sum);
        over   = sum_s > MAX_V;
        under  = sum_s < MIN_V;
        flag_d = over || under;
        out_d  = s2_q.sum[DATA_W-1:0];
        if (s2_q.sat && over)
            out_d = OUT_MAX;
        else if (s2_q.sat && under)
            out_d = OUT_MIN;
    end

    // Payload registers load only with a valid vector so a stalled output never changes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1       <= 1'b0;
            v2       <= 1'b0;
            v3       <= 1'b0;
            s1_q     <= '0;
            s2_q     <= '0;
            out      <= '0;
            sat_flag <= 1'b0;
        end else begin
            if (ld1) v1 <= in_valid;
            if (ld2) v2 <= v1;
            if (ld3) v3 <= v2;
            if (ld1 && in_valid) s1_q <= s1_d;
            if (ld2 && v1) s2_q <= s2_d;
            if (ld3 && v2) begin
                out      <= out_d;
                sat_flag <= flag_d;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ovf_cnt <= '0;
        else if (cnt_clr)
            ovf_cnt <= '0;
        else if (v3 && out_ready && sat_flag && ovf_cnt != '1)
            ovf_cnt <= ovf_cnt + CNT_W'(1);
    end

endmodule
